adc_spi_scan: RTL

//  Parametrised serial-ADC front end for MAX1379-class converters: generates CNVST/SCLK/CS,

---
 rtl/adc_spi_scan_if.sv | 36 +++
 rtl/adc_spi_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_scan_if.sv
// Pin and result bundle for the serial-ADC scanner.
// Latency: none (wires only).
// Backpressure: none; valid_o is a one-clk strobe with no ready.
interface adc_spi_scan_if #(
    parameter int DATA_W = 12,
    parameter int N_CH   = 2
);
    // Control from the sample-processing side
    logic              start;
    logic              cont;
    logic [N_CH-1:0]   ch_mask;
    // ADC serial data pin
    logic              out0;
    // ADC control pins
    logic              cnvst;
    logic              cs;
    logic              sclk;
    logic [1:0]        ch_sel;
    // Result towards the sample-processing side
    logic [DATA_W-1:0] data_o;
    logic [1:0]        ch_o;
    logic              valid_o;
    logic              busy;

    // Environment view: drives requests and the ADC data pin
    modport master (
        output start, cont, ch_mask, out0,
        input  cnvst, cs, sclk, ch_sel, data_o, ch_o, valid_o, busy
    );

    // Scanner view
    modport slave (
        input  start, cont, ch_mask, out0,
        output cnvst, cs, sclk, ch_sel, data_o, ch_o, valid_o, busy
    );
endinterface

// File: rtl/adc_spi_scan.sv
// Serial-ADC scanner: drives CNVST/SCLK/CS, walks the channel mask, shifts results in MSB first.
// Latency: start in cycle 0 -> valid_o in cycle 2+CLK_DIV+(T-1)*2*CLK_DIV, T=ACQ+LAT+DATA_W SCLK rises.
// Backpressure: none; start while busy is held one-deep in pending. Option: ADC_AVG4_EN (4x averaging).
module adc_spi_scan #(
    parameter int DATA_W     = 12,
    parameter int CLK_DIV    = 4,
    parameter int N_CH       = 2,
    parameter int ACQ_PULSES = 31,
    parameter int LAT_PULSES = 5
) (
    input  logic          clk,
    input  logic          rst,
    adc_spi_scan_if.slave bus
);

    localparam int MAXC0 = (ACQ_PULSES > LAT_PULSES) ? ACQ_PULSES : LAT_PULSES;
    localparam int MAXC  = (MAXC0 > DATA_W) ? MAXC0 : DATA_W;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] ACQ_LAST = CNT_W'(ACQ_PULSES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_PULSES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CONV,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic              sclk_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        ch_o_q;
    logic              valid_q;
    logic [1:0]        ch_sel_q;
    logic              sel_vld_q;
    logic              pending_q;
    logic              rise;
    logic              frame_final;
    logic              cnvst_d;
    logic              cs_d;
    logic [DATA_W-1:0] result;

`ifdef ADC_AVG4_EN
    logic [DATA_W+1:0] acc_q;
    logic [DATA_W+1:0] acc_sum;
    logic [1:0]        avg_cnt_q;
`endif

    // Lowest enabled channel, 0 when the mask is empty
    function automatic logic [1:0] lowest_ch(input logic [N_CH-1:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next enabled channel above cur, wrapping to the lowest
    function automatic logic [1:0] next_ch(input logic [N_CH-1:0] m, input logic [1:0] cur);
        logic [1:0] r;
        r = lowest_ch(m);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = 2'(i);
        end
        return r;
    endfunction

    // A rise tick is the clk cycle whose edge takes sclk from 0 to 1
    assign rise = (state_q inside {S_SETUP, S_CONV, S_SHIFT}) && (div_q == DIV_LAST) && !sclk_q;

    // Averaging: only every fourth conversion of a channel closes out a result
`ifdef ADC_AVG4_EN
    assign acc_sum     = acc_q + {2'b00, shift_q};
    assign frame_final = (avg_cnt_q == 2'd3);
    assign result      = acc_sum[DATA_W+1:2];
`else
    assign frame_final = 1'b1;
    assign result      = shift_q;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and pin decode
    always_comb begin
        state_d = state_q;
        cnvst_d = 1'b1;
        cs_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cs_d = 1'b1;
                if ((bus.start || bus.cont) && (|bus.ch_mask)) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (rise && (cnt_q == ACQ_LAST)) state_d = S_CONV;
            end
            S_CONV: begin
                cnvst_d = 1'b0;
                if (rise && (cnt_q == LAT_LAST)) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnvst_d = 1'b0;
                if (rise && (cnt_q == BIT_LAST)) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.ch_mask == '0)
                    state_d = S_IDLE;
                else if (!frame_final || bus.cont || pending_q || bus.start)
                    state_d = S_SETUP;
                else
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SCLK divider: parked low between frames so every frame starts from a clean phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (state_q == S_IDLE || state_q == S_DONE) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    // Rise-tick counter per phase, plus MSB-first deserialiser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            if (state_q == S_IDLE || state_q == S_DONE)
                cnt_q <= '0;
            else if (rise)
                cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            if (state_q == S_SHIFT && rise)
                shift_q <= {shift_q[DATA_W-2:0], bus.out0};
        end
    end

    // Result delivery, channel walk and request merging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            ch_o_q    <= 2'd0;
            valid_q   <= 1'b0;
            ch_sel_q  <= 2'd0;
            sel_vld_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // First frame after reset latches the lowest enabled channel
            if (state_q == S_IDLE && state_d == S_SETUP && !sel_vld_q) begin
                ch_sel_q  <= lowest_ch(bus.ch_mask);
                sel_vld_q <= 1'b1;
            end
            if (state_q == S_DONE) begin
                if (frame_final) begin
                    data_q   <= result;
                    ch_o_q   <= ch_sel_q;
                    valid_q  <= 1'b1;
                    ch_sel_q <= next_ch(bus.ch_mask, ch_sel_q);
                end
                // A request is consumed at the closing frame; mid-average it is kept
                if (bus.ch_mask == '0 || frame_final) pending_q <= 1'b0;
                else                                   pending_q <= pending_q | bus.start;
            end else if (state_q != S_IDLE) begin
                pending_q <= pending_q | bus.start;
            end
        end
    end

`ifdef ADC_AVG4_EN
    // Four-sample accumulator; an aborted average is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            avg_cnt_q <= 2'd0;
        end else if (state_q == S_DONE) begin
            if (frame_final || bus.ch_mask == '0) begin
                acc_q     <= '0;
                avg_cnt_q <= 2'd0;
            end else begin
                acc_q     <= acc_sum;
                avg_cnt_q <= avg_cnt_q + 2'd1;
            end
        end
    end
`endif

    assign bus.cnvst   = cnvst_d;
    assign bus.cs      = cs_d;
    assign bus.sclk    = sclk_q;
    assign bus.ch_sel  = sel_vld_q ? ch_sel_q : lowest_ch(bus.ch_mask);
    assign bus.data_o  = data_q;
    assign bus.ch_o    = ch_o_q;
    assign bus.valid_o = valid_q;
    assign bus.busy    = (state_q != S_IDLE);

endmodule
